// File: rtl/fifo_arb_pkg.sv
// Shared state type and index helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // The wrap is explicit so that requester counts that are not a power of two stay in range.
  function automatic int unsigned next_idx(int unsigned idx, int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    // ptr itself is visited last, so it has the lowest priority.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'(next_idx(32'(cand), $unsigned(NUM_REQ)));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port among NUM_REQ requesters, with round-robin arbitration.
// Each grant is held until the requester's packet ends, so packets never interleave in the FIFO.
//
// state    | meaning
// ARB_IDLE | no grant; looks for a valid requester after rr_ptr
// ARB_BUSY | requester g owns the write port until its last beat transfers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [DATA_WIDTH-1:0] i_req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]    i_req_last,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic                  i_wfull,
  output logic                  o_winc,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic [ID_WIDTH-1:0]   o_grant_id
);

  arb_state_e          state;
  logic [ID_WIDTH-1:0] g;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] pick_ptr;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  g_mask;
  logic                pick_found;

  assign o_grant_id = g;

  // One picker serves both the idle pick and the zero-bubble handover on a last beat.
  always_comb begin
    g_mask    = '0;
    g_mask[g] = 1'b1;
    pick_req  = i_req_valid;
    pick_ptr  = rr_ptr;
    if (state == ARB_BUSY) begin
      pick_req = i_req_valid & ~g_mask;
      pick_ptr = g;
    end
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    o_req_ready = '0;
    o_winc      = 1'b0;
    o_wdata     = '0;
    if (state == ARB_BUSY) begin
      o_req_ready[g] = ~i_wfull;
      o_winc         = i_req_valid[g] & ~i_wfull;
      o_wdata        = i_req_data[g];
    end
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state  <= ARB_IDLE;
      g      <= '0;
      rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
      o_busy <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state  <= ARB_BUSY;
            g      <= pick_idx;
            o_busy <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (o_winc && i_req_last[g]) begin
            rr_ptr <= g;
            if (pick_found) begin
              g <= pick_idx;
            end else begin
              state  <= ARB_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ARB_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-clock-domain arbiter that shares the single write port of the async FIFO among NUM_REQ requesters.
- Grants one requester at a time using round-robin priority.
- Holds the grant until that requester's packet ends (last beat), so packets are never interleaved in the FIFO.
- Drives the FIFO write increment and write data directly; back-pressure comes from the FIFO full flag.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..16.
- DATA_WIDTH, 8: FIFO write data width.
- ID_WIDTH, $clog2(NUM_REQ): width of the grant index.

Ports:
- i_wclk  input  1  write-domain clock.
- i_wrst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester beat valid.
- i_req_data  input  NUM_REQ x DATA_WIDTH  per-requester beat data, unpacked array.
- i_req_last  input  NUM_REQ  marks the final beat of a packet.
- o_req_ready  output  NUM_REQ  per-requester beat accepted this cycle when valid is also high.
- i_wfull  input  1  FIFO full flag, already in the write domain.
- o_winc  output  1  FIFO write enable.
- o_wdata  output  DATA_WIDTH  FIFO write data.
- o_busy  output  1  a packet grant is active.
- o_grant_id  output  ID_WIDTH  index of the current or most recent grantee.

Behaviour:
- **Clock and reset.** One clock, i_wclk. Reset is asynchronous and active-low on i_wrst_n.
- **Reset values.**
  - State = IDLE; o_busy = 0; o_grant_id = 0.
  - Round-robin pointer rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
  - o_winc = 0, o_req_ready = 0, o_wdata = 0.
- **States.** IDLE and BUSY, with registered grant g.
- **IDLE.**
  - o_req_ready = 0 and o_winc = 0.
  - If any i_req_valid is high, pick the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Next cycle: BUSY, g = pick, o_grant_id = pick. Arbitration latency is 1 cycle.
- **BUSY, per cycle (combinational write path, no added latency).**
  - o_req_ready[g] = ~i_wfull; all other ready bits are 0.
  - o_winc = i_req_valid[g] & ~i_wfull.
  - o_wdata = i_req_data[g] whenever BUSY, and 0 in IDLE.
- **Transfer.** A transfer occurs when o_winc = 1. The FIFO's wfull already accounts for winc on the next edge, so overflow is impossible.
- **Last beat.** On a transfer with i_req_last[g] = 1:
  - rr_ptr <= g.
  - Re-arbitrate in the same cycle from g+1 over the current i_req_valid, excluding bit g.
  - If a winner exists: stay BUSY with the new g and o_grant_id, giving a zero-bubble handover.
  - Otherwise: go to IDLE.
- **Requester g drops valid mid-packet.** The grant is held indefinitely, with no timeout. Other requesters wait.
- **i_wfull high.** No transfer and no state change. Grant is held.
- **Single-beat packets** (valid and last together) are legal.
- **Masking.** i_req_last is ignored unless it coincides with a transfer. i_req_valid bits of non-granted requesters never affect o_winc.
- **Simultaneous requests.** Strict round-robin: after requester k completes, k is lowest priority.
- **Reset mid-packet.** Everything returns to reset values immediately. Requesters must restart the packet.
- **Index arithmetic.** Index math is modulo NUM_REQ. For non-power-of-2 NUM_REQ the wrap must be explicit, never relying on natural overflow.

Decomposition:
- **Package fifo_arb_pkg.**
  - Contains the state enum arb_state_e {ARB_IDLE, ARB_BUSY}.
  - Contains the function next_idx(idx, n), which implements the modulo wrap.
- **Sub-module rr_pick.**
  - Combinational, parameterised by NUM_REQ.
  - Inputs: request vector and pointer. Outputs: found flag and index.
  - Used for both the IDLE pick and the last-beat handover.

Test Plan:
1. **Reset:** hold i_wrst_n=0 with all valid=1 → o_winc=0, o_req_ready=0000, o_busy=0, o_grant_id=0. Release → 1 cycle later o_busy=1, o_grant_id=0.
2. **Round robin:** valid=1111, each requester sends single-beat packets with data 8'hA0+id → FIFO receives A0,A1,A2,A3,A0 on consecutive cycles, no bubbles after the first.
3. **Packet lock:** req1 sends a 4-beat packet (last on beat 4) while req2 is valid throughout → four req1 beats, then req2. No interleaving; o_grant_id=1 for 4 transfers.
4. **Full stall:** i_wfull=1 for 3 cycles in the middle of req0's 3-beat packet → o_winc=0 and o_req_ready[0]=0 during the stall. The packet resumes and the beat count is exactly 3.
5. **Valid gap:** req3 drops valid for 5 cycles mid-packet while req0 is valid → no req0 writes until req3's last beat completes.
6. **Async reset mid-packet:** assert i_wrst_n=0 between clock edges during a transfer → outputs are 0 immediately, without waiting for an edge. After release, arbitration restarts from requester 0.
